// File: rtl/hex_pager.sv
// Digit pager: loads a stream of hex digits into a buffer and shows a window of
// them on NUM_HEX seven-segment displays, paged by debounced push buttons or auto-scrolled.
module hex_pager #(
  parameter int NUM_HEX    = 6,
  parameter int DEPTH      = 64,
  parameter int DEBOUNCE   = 16,
  parameter int SCROLL_DIV = 50000000,
  localparam int AW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           key,
  input  logic                 in_valid,
  input  logic [3:0]           in_digit,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [7*NUM_HEX-1:0] hex,
  output logic [AW-1:0]        count,
  output logic                 viewing
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH + NUM_HEX + 1);
  localparam int TW = $clog2(SCROLL_DIV + 1);
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {LOAD = 2'd0, VIEW = 2'd1, SCROLL = 2'd2} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   offset;
  logic [TW-1:0]   timer;
  logic [3:0]      buf_mem [DEPTH];
  logic [3:0]      sync1, sync2, db_lvl, press;
  logic [CW-1:0]   stab_cnt [4];
  logic            wr, wr_end, act_toggle, act_next, act_prev;
  logic [PW-1:0]   next_sum, disp_pos;
  logic [7*NUM_HEX-1:0] hex_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  4'hF: seg7 = 7'h0E;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  // Per-key debounce; a press pulse fires when the accepted level falls to 0
  always_ff @(posedge clk) begin
    if (rst) begin
      db_lvl <= 4'hF;
      press  <= 4'h0;
      for (int i = 0; i < 4; i++) stab_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] != db_lvl[i]) begin
          if (stab_cnt[i] == CW'(DEBOUNCE - 1)) begin
            db_lvl[i]   <= sync2[i];
            stab_cnt[i] <= '0;
            press[i]    <= ~sync2[i];
          end else begin
            stab_cnt[i] <= stab_cnt[i] + CW'(1);
          end
        end else begin
          stab_cnt[i] <= '0;
        end
      end
    end
  end

  // Action decode: key[3] beats key[2] beats key[0] beats key[1]; clear also drops a write
  always_comb begin
    wr         = in_valid && in_ready && !press[3];
    wr_end     = wr && (in_last || (count == AW'(DEPTH - 1)));
    act_toggle = !press[3] && press[2] && (state != LOAD);
    act_next   = !press[3] && !press[2] && press[0] && (state == VIEW);
    act_prev   = !press[3] && !press[2] && !press[0] && press[1] && (state == VIEW);
    next_sum   = PW'(offset) + PW'(NUM_HEX);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (press[3]) begin
      state_next = LOAD;
    end else begin
      case (state)
        LOAD:    state_next = wr_end ? VIEW : LOAD;
        VIEW:    state_next = act_toggle ? SCROLL : VIEW;
        SCROLL:  state_next = act_toggle ? VIEW : SCROLL;
        default: state_next = LOAD;
      endcase
    end
  end

  // Output decode from state
  always_comb begin
    in_ready = (state == LOAD) && (count < AW'(DEPTH));
    viewing  = (state != LOAD);
  end

  // Count, page offset and scroll timer
  always_ff @(posedge clk) begin
    if (rst || press[3]) begin
      count  <= '0;
      offset <= '0;
      timer  <= '0;
    end else begin
      if (wr) count <= count + AW'(1);
      else    count <= count;
      case (state)
        VIEW: begin
          timer <= '0;
          if (act_next)      offset <= (next_sum < PW'(count)) ? offset + AW'(NUM_HEX) : '0;
          else if (act_prev) offset <= (PW'(offset) >= PW'(NUM_HEX)) ? offset - AW'(NUM_HEX) : '0;
          else               offset <= offset;
        end
        SCROLL: begin
          if (act_toggle) begin
            timer <= '0;
          end else if (timer == TW'(SCROLL_DIV - 1)) begin
            timer  <= '0;
            offset <= ((offset + AW'(1)) == count) ? '0 : offset + AW'(1);
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          offset <= '0;
          timer  <= '0;
        end
      endcase
    end
  end

  // Digit buffer (contents survive reset)
  always_ff @(posedge clk) begin
    if (wr) buf_mem[count[IW-1:0]] <= in_digit;
  end

  // Window decode: leftmost display shows buffer[offset]
  always_comb begin
    hex_next = '1;
    disp_pos = '0;
    for (int j = 0; j < NUM_HEX; j++) begin
      disp_pos = PW'(offset) + PW'(j);
      if ((state != LOAD) && (disp_pos < PW'(count))) begin
        hex_next[7*(NUM_HEX-1-j) +: 7] = seg7(buf_mem[IW'(disp_pos)]);
      end else begin
        hex_next[7*(NUM_HEX-1-j) +: 7] = 7'h7F;
      end
    end
  end

  // Registered display drive
  always_ff @(posedge clk) begin
    if (rst) hex <= '1;
    else     hex <= hex_next;
  end

endmodule

// File: tb/tb_hex_pager.sv
// Self-checking bench for hex_pager: directed scenarios plus randomized loads and
// paging, checked against a digit-list model of the pager.
module tb_hex_pager;
  localparam int NH = 6, DP = 16, DB = 4, SD = 8;
  localparam logic [6:0] SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    key = 4'hF;
  logic          in_valid = 1'b0;
  logic [3:0]    in_digit = 4'h0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [7*NH-1:0] hex;
  logic [4:0]    count;
  logic          viewing;

  int n_assert = 0;
  int n_fail   = 0;
  int m_cnt = 0, m_off = 0, m_view = 0;
  int m_buf [DP];
  int cyc;

  hex_pager #(.NUM_HEX(NH), .DEPTH(DP), .DEBOUNCE(DB), .SCROLL_DIV(SD)) dut (
    .clk(clk), .rst(rst), .key(key), .in_valid(in_valid), .in_digit(in_digit),
    .in_last(in_last), .in_ready(in_ready), .hex(hex), .count(count), .viewing(viewing)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7*NH-1:0] exp_hex();
    logic [7*NH-1:0] r;
    r = '1;
    for (int j = 0; j < NH; j++) begin
      if (m_view != 0 && (m_off + j) < m_cnt) r[7*(NH-1-j) +: 7] = SEG_TBL[m_buf[m_off + j]];
    end
    return r;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, "_hex"}, hex, exp_hex());
    chk({tag, "_count"}, count, m_cnt);
    chk({tag, "_viewing"}, viewing, m_view);
  endtask

  task automatic write_digit(input int d, input bit last);
    chk("in_ready_before_write", in_ready, 1);
    in_valid = 1'b1;
    in_digit = d[3:0];
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_buf[m_cnt] = d;
    m_cnt++;
    if (last || m_cnt == DP) begin
      m_view = 1;
      m_off  = 0;
    end
  endtask

  // Hold buttons (active-low mask of pressed keys) long enough to debounce, then release
  task automatic press(input logic [3:0] mask);
    key = ~mask;
    repeat (12) tick();
    key = 4'hF;
    repeat (12) tick();
    if (mask[3]) begin
      m_cnt = 0; m_off = 0; m_view = 0;
    end else if (m_view == 1 && mask[0]) begin
      m_off = (m_off + NH < m_cnt) ? m_off + NH : 0;
    end else if (m_view == 1 && mask[1]) begin
      m_off = (m_off >= NH) ? m_off - NH : 0;
    end
  endtask

  task automatic wait_change(output int c);
    logic [7*NH-1:0] prev;
    prev = hex;
    c = 0;
    do begin
      tick();
      c++;
    end while (hex === prev && c < 40);
  endtask

  initial begin
    int seq [8] = '{3, 1, 4, 1, 5, 9, 2, 6};
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_hex", hex, {7*NH{1'b1}});
    chk("reset_in_ready", in_ready, 1);
    chk("reset_viewing", viewing, 0);
    chk("reset_count", count, 0);

    // load 3,1,4,1,5,9,2,6
    for (int i = 0; i < 8; i++) write_digit(seq[i], i == 7);
    repeat (2) tick();
    chk_all("load");
    chk("load_literal", hex, {7'h30, 7'h79, 7'h19, 7'h79, 7'h12, 7'h10});

    // paging
    press(4'b0001);
    chk_all("page_next");
    chk("page_literal", hex, {7'h24, 7'h02, 7'h7F, 7'h7F, 7'h7F, 7'h7F});
    press(4'b0001);
    chk_all("page_wrap");
    press(4'b0010);
    chk_all("page_prev_sat");

    // debounce: a 3-cycle glitch is ignored, a long hold pages exactly once
    key = 4'b1110;
    repeat (3) tick();
    key = 4'hF;
    repeat (20) tick();
    chk_all("glitch_ignored");
    key = 4'b1110;
    repeat (50) tick();
    key = 4'hF;
    repeat (12) tick();
    m_off = (m_off + NH < m_cnt) ? m_off + NH : 0;
    chk_all("long_hold_once");
    press(4'b0010);
    chk_all("back_to_zero");

    // auto scroll every SD cycles with wrap; key[0] ignored while scrolling
    key = 4'b1011;
    wait_change(cyc);
    chk("scroll_started", cyc < 40, 1);
    m_off = 1;
    chk_all("scroll_first");
    key = 4'hF;
    for (int s = 1; s <= 10; s++) begin
      if (s == 2) key = 4'b1110;
      if (s == 6) key = 4'hF;
      wait_change(cyc);
      chk("scroll_gap", cyc, SD);
      m_off = (m_off + 1) % m_cnt;
      chk_all("scroll_step");
    end
    press(4'b1000);
    chk_all("clear_from_scroll");

    // full buffer, then simultaneous key[3]+key[0]
    for (int i = 0; i < DP; i++) write_digit(i, 1'b0);
    chk("full_in_ready", in_ready, 0);
    repeat (2) tick();
    chk_all("full");
    press(4'b1001);
    chk_all("clear_priority");
    chk("clear_in_ready", in_ready, 1);

    // randomized loads and paging
    for (int r = 0; r < 5; r++) begin
      int n;
      n = $urandom_range(1, DP);
      for (int i = 0; i < n; i++) begin
        write_digit($urandom_range(0, 15), i == n - 1);
        repeat ($urandom_range(0, 2)) tick();
      end
      repeat (2) tick();
      chk_all("rand_load");
      for (int k = 0; k < 4; k++) begin
        press($urandom_range(0, 1) == 0 ? 4'b0001 : 4'b0010);
        chk_all("rand_page");
      end
      press(4'b1000);
      chk_all("rand_clear");
    end

    // reset in the middle of a load
    for (int i = 0; i < 5; i++) write_digit(i + 7, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_cnt = 0; m_off = 0; m_view = 0;
    chk("midreset_count", count, 0);
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_hex", hex, {7*NH{1'b1}});
    chk("midreset_viewing", viewing, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
